// File: rtl/game_sequencer.sv
// Purpose: top-level game flow sequencer (title, ready, play, death, level-up, game over, optional pause).
// Latency: every decision takes effect on the clk edge after its causing input; outputs decode registered state only.
// Backpressure: none; inputs are levels/strobes sampled every clk, outputs are steady levels.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   tick                one-cycle frame strobe
//   btn_c               centre button level (already synchronous)
//   pacman_dead         death level from game logic
//   level_clear         all-food-eaten level from game logic
//   logic_en            game logic may advance (PLAY only)
//   pos_rst             hold sprite positions in reset (IDLE, READY)
//   score_rst           hold score and food map in reset (IDLE)
//   lives, level        remaining lives, current level
//   state               encoded state
//   banner              overlay select: 0 none, 1 TITLE, 2 READY, 3 GAME OVER
//
// Optional feature: define GAME_SEQ_PAUSE_EN to add the PAUSE state
// (button press toggles PLAY <-> PAUSE).
module game_sequencer #(
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned READY_FRAMES = 120,
    parameter int unsigned PAUSE_FRAMES = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_c,
    input  logic       pacman_dead,
    input  logic       level_clear,
    output logic       logic_en,
    output logic       pos_rst,
    output logic       score_rst,
    output logic [2:0] lives,
    output logic [3:0] level,
    output logic [2:0] state,
    output logic [1:0] banner
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READY     = 3'd1,
        S_PLAY      = 3'd2,
        S_DYING     = 3'd3,
        S_LEVEL_UP  = 3'd4,
        S_GAME_OVER = 3'd5,
        S_PAUSE     = 3'd6
    } state_t;

    localparam logic [7:0] READY_CNT = 8'(READY_FRAMES);
    localparam logic [7:0] PAUSE_CNT = 8'(PAUSE_FRAMES);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_cnt_inc;
    logic [2:0] r_lives;
    logic [2:0] w_lives_nxt;
    logic [3:0] r_level;
    logic [3:0] w_level_nxt;
    logic       r_btn_q;
    logic       w_press;

    // Rising edge of the button; a single-cycle pulse, so it can drive at most one transition.
    assign w_press   = btn_c & ~r_btn_q;
    assign w_cnt_inc = r_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lives <= '0;
            r_level <= '0;
            // Held high so a button kept down through reset is not seen as a press.
            r_btn_q <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lives <= w_lives_nxt;
            r_level <= w_level_nxt;
            r_btn_q <= btn_c;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lives_nxt = r_lives;
        w_level_nxt = r_level;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_state_nxt = S_READY;
                    w_lives_nxt = 3'(LIVES_INIT);
                    w_level_nxt = 4'd1;
                end
            end
            S_READY: begin
                if (tick) begin
                    if (w_cnt_inc == READY_CNT) w_state_nxt = S_PLAY;
                    else                        w_cnt_nxt   = w_cnt_inc;
                end
            end
            S_PLAY: begin
                // Death outranks level clear (and pause), so a simultaneous clear is lost.
                if (pacman_dead)      w_state_nxt = S_DYING;
                else if (level_clear) w_state_nxt = S_LEVEL_UP;
`ifdef GAME_SEQ_PAUSE_EN
                else if (w_press)     w_state_nxt = S_PAUSE;
`endif
            end
            S_DYING: begin
                if (tick) begin
                    if (w_cnt_inc == PAUSE_CNT) begin
                        w_lives_nxt = r_lives - 3'd1;
                        if (r_lives == 3'd1) w_state_nxt = S_GAME_OVER;
                        else                 w_state_nxt = S_READY;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            S_LEVEL_UP: begin
                if (tick) begin
                    if (w_cnt_inc == PAUSE_CNT) begin
                        w_state_nxt = S_READY;
                        if (r_level != 4'd15) w_level_nxt = r_level + 4'd1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            S_GAME_OVER: begin
                // Lives remain 0 and score is not cleared so the final score stays visible.
                if (w_press) w_state_nxt = S_IDLE;
            end
`ifdef GAME_SEQ_PAUSE_EN
            S_PAUSE: begin
                // Counter held, death/clear ignored while paused.
                if (w_press) w_state_nxt = S_PLAY;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        // Counter restarts from zero in every new state; a tick in the transition cycle is dropped.
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    always_comb begin
        logic_en  = 1'b0;
        pos_rst   = 1'b0;
        score_rst = 1'b0;
        banner    = 2'd0;
        case (r_state)
            S_IDLE: begin
                pos_rst   = 1'b1;
                score_rst = 1'b1;
                banner    = 2'd1;
            end
            S_READY: begin
                pos_rst = 1'b1;
                banner  = 2'd2;
            end
            S_PLAY:      logic_en = 1'b1;
            S_GAME_OVER: banner   = 2'd3;
            S_PAUSE:     banner   = 2'd2;
            default: ;
        endcase
    end

    assign lives = r_lives;
    assign level = r_level;
    assign state = r_state;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded on game start, range 1..7.
REQ-002 Parameter READY_FRAMES, default 120: frame ticks spent in READY, range 1..255.
REQ-003 Parameter PAUSE_FRAMES, default 90: frame ticks spent in DYING and in LEVEL_UP, range 1..255.
REQ-004 Port list SHALL be:
- clk  in  1  system clock; one clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-cycle frame strobe, synchronous to clk.
- btn_c  in  1  centre button level, already synchronous to clk.
- pacman_dead  in  1  level from game logic.
- level_clear  in  1  level from game logic, high when all food is eaten.
- logic_en  out  1  game logic may advance.
- pos_rst  out  1  holds the sprite positions in reset.
- score_rst  out  1  holds score and food map in reset.
- lives  out  3  remaining lives.
- level  out  4  current level.
- state  out  3  encoded state.
- banner  out  2  overlay select: 0 none, 1 TITLE, 2 READY, 3 GAME OVER.

Function
REQ-005 States and state encodings SHALL be IDLE=0, READY=1, PLAY=2, DYING=3, LEVEL_UP=4, GAME_OVER=5, PAUSE=6; encodings 7 and any other unused code SHALL return to IDLE on the next clk.
REQ-006 press SHALL equal btn_c & ~btn_q, where btn_q is btn_c registered every clk; one press SHALL be consumed by at most one transition.
REQ-007 IDLE: on press -> READY, lives<=LIVES_INIT, level<=1.
REQ-008 READY: frame counter SHALL increment on each tick; the tick that makes it equal READY_FRAMES SHALL cause -> PLAY.
REQ-009 PLAY: pacman_dead -> DYING; otherwise level_clear -> LEVEL_UP; pacman_dead wins when both are high in the same cycle.
REQ-010 DYING: after PAUSE_FRAMES ticks, lives<=lives-1; go to GAME_OVER if lives was 1, else to READY.
REQ-011 LEVEL_UP: after PAUSE_FRAMES ticks -> READY, level<=level+1, level saturating at 15.
REQ-012 GAME_OVER: on press -> IDLE; lives SHALL stay 0 and score_rst SHALL stay 0 so the final score remains displayed.
REQ-013 The frame counter SHALL be 8 bits and SHALL clear on every state change.
- A tick arriving in the transition cycle SHALL NOT be counted.
REQ-014 Outputs SHALL be decoded from registered state only, with no input-to-output combinational path:
- logic_en=1 only in PLAY.
- pos_rst=1 in IDLE and READY.
- score_rst=1 in IDLE.
- banner: IDLE=1, READY=2, PAUSE=2, GAME_OVER=3, all others=0.
REQ-015 All outputs SHALL be level signals so that slower game-logic clocks sample them safely.
REQ-016 Each decision (transition, counter update, lives and level update) SHALL take effect on the clk edge following the causing input; latency is one cycle.

Reset
REQ-017 While rst=1 at a clk edge: state=IDLE, lives=0, level=0, counter=0, btn_q=1.
- btn_q=1 ensures a button held through reset does not register as a press.
REQ-018 Output values during and after reset: logic_en=0, pos_rst=1, score_rst=1, banner=1.
REQ-019 rst asserted in any state, including mid-count, SHALL abort that state in the same edge; no lives or level update SHALL occur.

Configuration
REQ-020 Macro GAME_SEQ_PAUSE_EN defined: in PLAY, a press -> PAUSE, and in PAUSE a press -> PLAY.
- In PAUSE: logic_en=0, the frame counter is held, pacman_dead and level_clear are ignored.
- pacman_dead still takes priority over a press in PLAY.
REQ-021 Macro GAME_SEQ_PAUSE_EN undefined: PAUSE state and its logic are absent, and press is ignored in PLAY.

Verification (LIVES_INIT=2, READY_FRAMES=4, PAUSE_FRAMES=3)
REQ-022 Reset with btn_c held at 1, then rst released -> state stays 0; banner=1; press registers only after btn_c falls and rises again.
REQ-023 Press in IDLE, then 4 ticks -> state 0->1->2; lives=2, level=1; logic_en rises one cycle after the 4th tick.
REQ-024 In PLAY, pacman_dead and level_clear high together -> DYING; after 3 ticks lives=1, state=READY, pos_rst=1, score_rst=0.
REQ-025 Second death followed by 3 ticks -> GAME_OVER, lives=0, banner=3; press -> IDLE, score_rst=1.
REQ-026 Sixteen consecutive level clears -> level saturates at 15 and does not wrap to 0.
REQ-027 With GAME_SEQ_PAUSE_EN, press in PLAY -> PAUSE with logic_en=0 and pacman_dead ignored; second press -> PLAY. Without the macro, press in PLAY leaves state at 2.
